// File: rtl/seq_multiplier4_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier4_if
//   Request/result bundle for the sequential multiplier.
//   start   : operation request, sampled while the multiplier is idle
//   a, b    : multiplicand / multiplier, captured with start
//   busy    : operation in progress
//   done    : one-cycle pulse, product newly updated
//   product : 2*WIDTH-bit result, held until the next completion
//   Modports: master drives the request, slave (the multiplier) answers.
// ---------------------------------------------------------------------------
interface seq_multiplier4_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier4.sv
// ---------------------------------------------------------------------------
// seq_multiplier4
//   Unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
//   Each iteration adds the (optionally gated) shifted multiplicand into the
//   accumulator through a structural ripple chain of full_adder cells.
//   A result takes WIDTH+1 clock edges from the accepting edge; a new start
//   is accepted in the done cycle, so back-to-back ops run every WIDTH+1.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any operation in flight)
//   bus  : seq_multiplier4_if.slave (start, a, b in; busy, done, product out)
// ---------------------------------------------------------------------------

// One-bit full adder cell used to build the accumulator ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_multiplier4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_multiplier4_if.slave   bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;

  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    mcand_r;
  logic [WIDTH-1:0] mreg_r;
  logic [CW-1:0]    cnt_r;
  logic [PW-1:0]    product_r;
  logic             done_r;

  logic [PW-1:0]    addend_s;
  logic [PW-1:0]    sum_s;
  logic [PW:0]      carry_s;
  logic             carry_unused_s;
  logic             busy_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  // The WIDTH-th iteration is the one that sees cnt == WIDTH-1.
  assign last_s = (cnt_r == CW'(WIDTH - 1));

  // Gate the multiplicand by the current multiplier LSB.
  always_comb begin
    addend_s = {PW{1'b0}};
    if (mreg_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {PW{1'b0}};
    end
  end

  // Structural accumulator adder: acc_r + addend_s, ripple carry from bit 0.
  assign carry_s[0] = 1'b0;
  for (genvar i = 0; i < PW; i++) begin : g_fa
    full_adder u_fa (
      .a    (acc_r[i]),
      .b    (addend_s[i]),
      .cin  (carry_s[i]),
      .sum  (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end
  // Final carry is always 0 because (2^W-1)^2 < 2^(2W); intentionally dropped.
  assign carry_unused_s = carry_s[PW];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State decode: busy flag and datapath enables.
  always_comb begin
    busy_s = 1'b0;
    load_s = 1'b0;
    step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        load_s = bus.start;
        step_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        load_s = 1'b0;
        step_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        load_s = 1'b0;
        step_s = 1'b0;
      end
    endcase
  end

  // Datapath registers: capture operands on accept, shift/accumulate in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {PW{1'b0}};
      mcand_r <= {PW{1'b0}};
      mreg_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
    end else if (load_s) begin
      acc_r   <= {PW{1'b0}};
      mcand_r <= {{WIDTH{1'b0}}, bus.a};
      mreg_r  <= bus.b;
      cnt_r   <= {CW{1'b0}};
    end else if (step_s) begin
      acc_r   <= sum_s;
      mcand_r <= mcand_r << 1;
      mreg_r  <= mreg_r >> 1;
      cnt_r   <= cnt_r + CW'(1);
    end else begin
      acc_r   <= acc_r;
      mcand_r <= mcand_r;
      mreg_r  <= mreg_r;
      cnt_r   <= cnt_r;
    end
  end

  // Result registers: product and done update only on the completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      product_r <= {PW{1'b0}};
      done_r    <= 1'b0;
    end else if (step_s && last_s) begin
      product_r <= sum_s;
      done_r    <= 1'b1;
    end else begin
      product_r <= product_r;
      done_r    <= 1'b0;
    end
  end

  assign bus.busy    = busy_s;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_seq_multiplier4.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier4
//   Directed self-checking bench for seq_multiplier4 (WIDTH=4).
//   Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_seq_multiplier4;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_multiplier4_if #(.WIDTH(4)) bus ();

  seq_multiplier4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: issue one op, wait for done (bounded). lat counts edges
  // from the accepting edge through the completing edge.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        output logic [7:0] prod, output logic busy_first,
                        output logic [7:0] prod_during, output int lat,
                        output bit timeout);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    busy_first  = bus.busy;
    prod_during = bus.product;
    lat         = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    timeout = (bus.done !== 1'b1);
    prod    = bus.product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    total++;
    if (bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    total++;
    if (bus.product !== 8'h00) begin
      bad++;
      $display("FAIL reset_product: got %h expected 00", bus.product);
    end
    rst = 1'b0;
  endtask

  task automatic test_max();
    logic [7:0] p;
    logic [7:0] pd;
    logic       bf;
    int         lat;
    bit         to;
    run_op(4'hF, 4'hF, p, bf, pd, lat, to);
    total++;
    if (to || p !== 8'hE1) begin
      bad++;
      $display("FAIL max_product: got %h (timeout=%0d) expected e1", p, to);
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL max_latency: got %0d expected 5", lat);
    end
    total++;
    if (bf !== 1'b1) begin
      bad++;
      $display("FAIL max_busy: got %b expected 1", bf);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL max_after: done=%b busy=%b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_patterns();
    logic [7:0] p;
    logic [7:0] pd;
    logic       bf;
    int         lat;
    bit         to;
    run_op(4'hA, 4'h3, p, bf, pd, lat, to);
    total++;
    if (to || p !== 8'h1E) begin
      bad++;
      $display("FAIL a_x_3_product: got %h expected 1e", p);
    end
    run_op(4'h0, 4'h9, p, bf, pd, lat, to);
    total++;
    if (to || p !== 8'h00) begin
      bad++;
      $display("FAIL zero_product: got %h expected 00", p);
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL zero_latency: got %0d expected 5", lat);
    end
    total++;
    if (pd !== 8'h1E) begin
      bad++;
      $display("FAIL product_hold_in_run: got %h expected 1e", pd);
    end
  endtask

  task automatic test_back_to_back();
    int  ndone;
    logic exp_done;
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'h2;
    bus.b = 4'h3;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 12) bus.start = 1'b0;
      exp_done = (k == 5 || k == 10 || k == 15);
      total++;
      if (bus.done !== exp_done) begin
        bad++;
        $display("FAIL b2b_done_k%0d: got %b expected %b", k, bus.done, exp_done);
      end
      if (bus.done === 1'b1) begin
        ndone++;
        total++;
        if (bus.product !== 8'h06) begin
          bad++;
          $display("FAIL b2b_product_k%0d: got %h expected 06", k, bus.product);
        end
      end
    end
    total++;
    if (ndone != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d expected 3", ndone);
    end
  endtask

  task automatic test_ignore_start();
    int ndone;
    int done_k;
    ndone  = 0;
    done_k = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'h5;
    bus.b = 4'h7;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
      end else if (k == 2) begin
        bus.start = 1'b1;
        bus.a = 4'hF;
        bus.b = 4'hF;
      end else begin
        bus.start = 1'b0;
        bus.a = 4'h0;
        bus.b = 4'h0;
      end
      if (bus.done === 1'b1) begin
        ndone++;
        done_k = k;
      end
    end
    total++;
    if (ndone != 1 || done_k != 5) begin
      bad++;
      $display("FAIL ignore_done: got count=%0d at=%0d expected 1 at 5", ndone, done_k);
    end
    total++;
    if (bus.product !== 8'h23) begin
      bad++;
      $display("FAIL ignore_product: got %h expected 23", bus.product);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_midop();
    int ndone;
    int nbusy;
    ndone = 0;
    nbusy = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 4'hF;
    bus.b = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    total++;
    if (bus.product !== 8'h00) begin
      bad++;
      $display("FAIL midrst_product: got %h expected 00", bus.product);
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) nbusy++;
    end
    total++;
    if (ndone != 0 || nbusy != 0) begin
      bad++;
      $display("FAIL midrst_after: done_count=%0d busy_count=%0d expected 0 0", ndone, nbusy);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] p;
    logic [7:0] pd;
    logic [7:0] exp_p;
    logic       bf;
    int         lat;
    bit         to;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        exp_p = 8'(i * j);
        run_op(4'(i), 4'(j), p, bf, pd, lat, to);
        total++;
        if (to || p !== exp_p || lat != 5) begin
          bad++;
          $display("FAIL exh_%0d_x_%0d: got %h lat=%0d timeout=%0d expected %h lat=5",
                   i, j, p, lat, to, exp_p);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    test_reset();
    test_max();
    test_patterns();
    test_back_to_back();
    test_ignore_start();
    test_reset_midop();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
